stuff_remover: RTL and testbench

- Receive-side counterpart of the stuff/data slot marker.
- Takes a slotted word stream framed by sof_in, with per-frame slot count pm and data count cm.
- Regenerates the identical data/stuff slot pattern internally, forwards only data-slot words and drops stuff slots.
- Flags frame-alignment and configuration errors; sits between the line deframer and the payload buffer.

---
 rtl/stuff_pkg.sv | 23 ++
 rtl/slot_pattern_gen.sv | 44 ++++
 rtl/stuff_remover.sv | 150 +++++++++++++++
 tb/tb_stuff_remover.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stuff_pkg.sv
// stuff_pkg: shared types and helpers for the stuff/data slot
// marker and remover pair.
package stuff_pkg;

  localparam int MPT_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W      = MPT_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_SOF
  } state_e;

  // A frame needs at least two slots and 1..pm data slots.
  function automatic logic legal_cfg(
    input int unsigned pm,
    input int unsigned cm
  );
    return (pm >= 2) && (cm >= 1) && (cm <= pm);
  endfunction

endpackage

// File: rtl/slot_pattern_gen.sv
// slot_pattern_gen: regenerates the data/stuff slot pattern
// ds_j = ((j*cm) mod pm) < cm with a modulo accumulator.
module slot_pattern_gen
  import stuff_pkg::*;
#(
  parameter int MPT_W = MPT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [MPT_W-1:0] pm_i,
  input  logic [MPT_W-1:0] cm_i,
  output logic             ds_o,
  output logic             last_o
);

  localparam int AW = MPT_W + 1;

  logic [AW-1:0]    acc_q, acc_d, base, s;
  logic [MPT_W-1:0] j_q, j_d;

  // Pattern bit and next accumulator for the slot being stepped.
  always_comb begin
    base   = start_i ? '0 : acc_q;
    s      = base + {1'b0, cm_i};
    ds_o   = (s >= {1'b0, pm_i});
    acc_d  = ds_o ? (s - {1'b0, pm_i}) : s;
    j_d    = start_i ? MPT_W'(1) : (j_q + 1'b1);
    last_o = (j_d == pm_i);
  end

  // Advance accumulator and slot index on every stepped slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      j_q   <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      j_q   <= j_d;
    end
  end

endmodule

// File: rtl/stuff_remover.sv
// stuff_remover: forwards data slots of a framed slot stream,
// drops stuff slots and flags framing/config errors.
module stuff_remover
  import stuff_pkg::*;
#(
  parameter int MPT_W  = MPT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MPT_W-1:0]  pm,
  input  logic [MPT_W-1:0]  cm,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sof_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sof_out,
  output logic              eof_out,
  output logic              ds_out,
  output logic              err_sof_early,
  output logic              err_sof_late,
  output logic              input_err
);

  state_e state_q, state_d;

  logic [MPT_W-1:0]  pm_q, pm_d, cm_q, cm_d;
  logic [MPT_W-1:0]  pm_eff, cm_eff;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic ds_q, ds_d, early_q, early_d;
  logic late_q, late_d, ierr_q, ierr_d;
  logic seen_q, seen_d, arm_q, arm_d;
  logic start, step, ds, last;

  // A starting slot uses the config being sampled right now.
  assign pm_eff = start ? pm : pm_q;
  assign cm_eff = start ? cm : cm_q;

  slot_pattern_gen #(
    .MPT_W (MPT_W)
  ) u_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .step_i  (step),
    .pm_i    (pm_eff),
    .cm_i    (cm_eff),
    .ds_o    (ds),
    .last_o  (last)
  );

  // Frame FSM and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    pm_d    = pm_q;
    cm_d    = cm_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ds_d    = ds_q;
    early_d = 1'b0;
    late_d  = 1'b0;
    ierr_d  = 1'b0;
    seen_d  = seen_q;
    arm_d   = arm_q;
    start   = 1'b0;
    step    = 1'b0;
    if (valid_in) begin
      if (sof_in) begin
        pm_d    = pm;
        cm_d    = cm;
        early_d = (state_q == RUN);
        arm_d   = 1'b0;
        if (legal_cfg(32'(pm), 32'(cm))) begin
          start   = 1'b1;
          step    = 1'b1;
          seen_d  = 1'b0;
          state_d = RUN;
        end else begin
          ierr_d  = 1'b1;
          state_d = WAIT_SOF;
        end
      end else if (state_q == RUN) begin
        step = 1'b1;
      end else begin
        late_d = arm_q;
      end
      if (step) begin
        ds_d = ds;
        if (ds) begin
          valid_d = 1'b1;
          data_d  = data_in;
          sof_d   = start | ~seen_q;
          eof_d   = last;
          seen_d  = 1'b1;
        end
        if (last) begin
          state_d = WAIT_SOF;
          arm_d   = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pm_q    <= '0;
      cm_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ds_q    <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      ierr_q  <= 1'b0;
      seen_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q    <= pm_d;
      cm_q    <= cm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ds_q    <= ds_d;
      early_q <= early_d;
      late_q  <= late_d;
      ierr_q  <= ierr_d;
      seen_q  <= seen_d;
      arm_q   <= arm_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign sof_out       = sof_q;
  assign eof_out       = eof_q;
  assign ds_out        = ds_q;
  assign err_sof_early = early_q;
  assign err_sof_late  = late_q;
  assign input_err     = ierr_q;

endmodule

// File: tb/tb_stuff_remover.sv
// tb_stuff_remover: directed self-checking bench for
// stuff_remover.
module tb_stuff_remover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pm = '0, cm = '0, data_in = '0;
  logic       sof_in = 1'b0, valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, sof_out, eof_out, ds_out;
  logic       err_sof_early, err_sof_late, input_err;
  logic [5:0] flags;
  logic [7:0] exp_d;
  int         errs = 0;
  int         checks = 0;

  stuff_remover dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pm            (pm),
    .cm            (cm),
    .data_in       (data_in),
    .sof_in        (sof_in),
    .valid_in      (valid_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .sof_out       (sof_out),
    .eof_out       (eof_out),
    .ds_out        (ds_out),
    .err_sof_early (err_sof_early),
    .err_sof_late  (err_sof_late),
    .input_err     (input_err)
  );

  always #5 clk = ~clk;

  // {valid, sof, eof, early, late, input_err}
  assign flags = {valid_out, sof_out, eof_out,
                  err_sof_early, err_sof_late, input_err};

  task automatic drive(input logic v, input logic s,
                       input logic [7:0] d,
                       input logic [7:0] p,
                       input logic [7:0] c);
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    data_in  = d;
    pm       = p;
    cm       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_d = 8'h00;
    checks++;
    if (flags !== 6'b0) begin
      errs++;
      $display("FAIL reset flags: got %b want 000000", flags);
    end
    checks++;
    if (data_out !== 8'h00 || ds_out !== 1'b0) begin
      errs++;
      $display("FAIL reset data: got %h/%b want 00/0",
               data_out, ds_out);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    logic [5:0] ef [5] = '{6'b000000, 6'b000000, 6'b110000,
                           6'b000000, 6'b101000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, w[i], 8'd5, 8'd2);
      if (ef[i][5]) exp_d = w[i];
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL basic flags slot %0d: got %b want %b",
                 i + 1, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL basic data slot %0d: got %h want %h",
                 i + 1, data_out, exp_d);
      end
    end
  endtask

  task automatic test_all_data_gaps();
    logic       v [7] = '{1, 0, 1, 0, 1, 0, 1};
    logic [7:0] w [7] = '{8'h10, 8'h55, 8'h11, 8'h66,
                          8'h12, 8'h77, 8'h13};
    logic [5:0] ef [7] = '{6'b110000, 6'b000000, 6'b100000,
                           6'b000000, 6'b100000, 6'b000000,
                           6'b101000};
    for (int i = 0; i < 7; i++) begin
      drive(v[i], i == 0, w[i], 8'd4, 8'd4);
      if (ef[i][5]) exp_d = w[i];
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL gaps flags step %0d: got %b want %b",
                 i, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL gaps data step %0d: got %h want %h",
                 i, data_out, exp_d);
      end
    end
  endtask

  task automatic test_sof_early();
    logic       s [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [5:0] ef [7] = '{6'b000000, 6'b000000, 6'b000100,
                           6'b000000, 6'b110000, 6'b000000,
                           6'b101000};
    logic [7:0] w;
    for (int i = 0; i < 7; i++) begin
      w = 8'h20 + 8'(i);
      drive(1'b1, s[i], w, 8'd5, 8'd2);
      if (ef[i][5]) exp_d = w;
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL early flags slot %0d: got %b want %b",
                 i, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL early data slot %0d: got %h want %h",
                 i, data_out, exp_d);
      end
    end
  endtask

  task automatic test_sof_late();
    logic       s [7] = '{1, 0, 0, 0, 1, 0, 0};
    logic [5:0] ef [7] = '{6'b000000, 6'b000000, 6'b111000,
                           6'b000010, 6'b000000, 6'b000000,
                           6'b111000};
    logic [7:0] w;
    for (int i = 0; i < 7; i++) begin
      w = 8'h30 + 8'(i);
      drive(1'b1, s[i], w, 8'd3, 8'd1);
      if (ef[i][5]) exp_d = w;
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL late flags slot %0d: got %b want %b",
                 i, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL late data slot %0d: got %h want %h",
                 i, data_out, exp_d);
      end
    end
  endtask

  task automatic test_input_err();
    logic       s [5] = '{1, 0, 1, 1, 0};
    logic [7:0] p [5] = '{8'd1, 8'd1, 8'd5, 8'd5, 8'd5};
    logic [7:0] c [5] = '{8'd1, 8'd1, 8'd0, 8'd6, 8'd6};
    logic [5:0] ef [5] = '{6'b000001, 6'b000000, 6'b000001,
                           6'b000001, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s[i], 8'h40 + 8'(i), p[i], c[i]);
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL ierr flags step %0d: got %b want %b",
                 i, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL ierr data step %0d: got %h want %h",
                 i, data_out, exp_d);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] ef [7] = '{6'b000000, 6'b000000, 6'b110000,
                           6'b000000, 6'b100000, 6'b000000,
                           6'b101000};
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 8'h50 + 8'(i);
      drive(1'b1, i == 0, w, 8'd7, 8'd3);
      if (ef[i][5]) exp_d = w;
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL rst pre flags slot %0d: got %b want %b",
                 i + 1, flags, ef[i]);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    exp_d = 8'h00;
    checks++;
    if (flags !== 6'b0 || data_out !== 8'h00) begin
      errs++;
      $display("FAIL rst async: got %b/%h want 000000/00",
               flags, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 4; i < 7; i++) begin
      drive(1'b1, 1'b0, 8'h50 + 8'(i), 8'd7, 8'd3);
      checks++;
      if (flags !== 6'b0 || data_out !== exp_d) begin
        errs++;
        $display("FAIL rst drop slot %0d: got %b/%h want 0/%h",
                 i + 1, flags, data_out, exp_d);
      end
    end
    for (int i = 0; i < 7; i++) begin
      w = 8'h60 + 8'(i);
      drive(1'b1, i == 0, w, 8'd7, 8'd3);
      if (ef[i][5]) exp_d = w;
      checks++;
      if (flags !== ef[i]) begin
        errs++;
        $display("FAIL rst new flags slot %0d: got %b want %b",
                 i + 1, flags, ef[i]);
      end
      checks++;
      if (data_out !== exp_d) begin
        errs++;
        $display("FAIL rst new data slot %0d: got %h want %h",
                 i + 1, data_out, exp_d);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_all_data_gaps();
    test_sof_early();
    test_sof_late();
    test_input_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
